// File: rtl/aes128_pkg.sv
// Shared AES-128 types, constants and GF(2^8) helpers used by the key
// schedule and the round datapath.
package aes128_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] key_t;

  localparam logic [7:0] AES_RCON_INIT  = 8'h01;
  localparam logic [7:0] AES_RCON_POLY  = 8'h1b;
  localparam logic [3:0] AES_LAST_ROUND = 4'd10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Multiply by x in GF(2^8), reducing by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Combinational SubWord: four AES byte S-boxes side by side.
// Each S-box is the GF(2^8) inverse (x^254, so 0 maps to 0) followed by
// the FIPS-197 affine transform.
module aes_sbox_word
  import aes128_pkg::*;
(
  input  word_t word_i,
  output word_t word_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p  = p ^ (aa & {8{b[i]}});
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 = x^(2+4+8+16+32+64+128) by repeated squaring.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_byte
    assign word_o[8*g +: 8] = sbox_byte(word_i[8*g +: 8]);
  end

endmodule

// File: rtl/aes_key_expand_128.sv
// Iterative AES-128 key schedule: loads a cipher key on start and hands out
// round keys 0..10 over a valid/ready handshake, one word-stage per round.
module aes_key_expand_128
  import aes128_pkg::*;
#(
  parameter int         NUM_ROUNDS = 10,
  parameter logic [7:0] RCON_INIT  = 8'h01
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         busy,
  output logic         done
);

  if (NUM_ROUNDS != 10) begin : g_bad_rounds
    $error("aes_key_expand_128: NUM_ROUNDS must be 10 for AES-128");
  end

  state_e     state_q, state_d;
  key_t       rk_q, rk_d;
  logic [3:0] round_q, round_d;
  logic [7:0] rcon_q, rcon_d;
  logic       done_q, done_d;

  word_t w0_s, w1_s, w2_s, w3_s;
  word_t sub_s, t_s, n0_s, n1_s, n2_s, n3_s;
  key_t  next_key_s;
  logic  accept_s;

  // Next round key from the current one; all XORs are word-wide.
  assign w0_s = rk_q[127:96];
  assign w1_s = rk_q[95:64];
  assign w2_s = rk_q[63:32];
  assign w3_s = rk_q[31:0];

  aes_sbox_word u_sbox (
    .word_i ({w3_s[23:0], w3_s[31:24]}),
    .word_o (sub_s)
  );

  assign t_s        = sub_s ^ {rcon_q, 24'h000000};
  assign n0_s       = w0_s ^ t_s;
  assign n1_s       = w1_s ^ n0_s;
  assign n2_s       = w2_s ^ n1_s;
  assign n3_s       = w3_s ^ n2_s;
  assign next_key_s = {n0_s, n1_s, n2_s, n3_s};

  assign accept_s = (state_q == RUN) && rk_ready;

  // Next-state logic: load in IDLE, advance or finish on accept in RUN.
  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rk_d    = key_in;
          round_d = 4'd0;
          rcon_d  = RCON_INIT;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (accept_s && (round_q == AES_LAST_ROUND)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (accept_s) begin
          rk_d    = next_key_s;
          round_d = round_q + 4'd1;
          rcon_d  = xtime(rcon_q);
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rk_q    <= '0;
      round_q <= 4'd0;
      rcon_q  <= RCON_INIT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end

  assign rk_valid = (state_q == RUN);
  assign busy     = (state_q == RUN);
  assign rk_out   = rk_q;
  assign rk_round = round_q;
  assign done     = done_q;

endmodule
